ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port 8-bit synchronous RAM (write-or-read per cycle, registered read data).
- Shares the RAM between requesters A and B, one access per cycle.
- Owns memory initialisation: after reset, or on a clear command, it sweeps every address and writes 0 before serving requesters.

Parameters:
- ADDR_W, 8, width of the RAM address bus.
- DATA_W, 8, width of the RAM data bus.
- DEPTH, 8, number of RAM words swept by the clear sequence (addresses 0..DEPTH-1); must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  pulse that requests a full-memory clear; sampled only in SERVE.
- a_req  in  1  requester A wants an access this cycle.
- a_we  in  1  A access type: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  combinational; A's access is issued to the RAM this cycle.
- a_rvalid  out  1  registered; a_rdata is valid for A's read granted last cycle.
- a_rdata  out  DATA_W  equals ram_dout.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- ram_we  out  1  to RAM write enable.
- ram_addr  out  ADDR_W  to RAM address.
- ram_din  out  DATA_W  to RAM write data.
- ram_dout  in  DATA_W  from RAM registered read data.
- init_done  out  1  high while in SERVE.
- busy  out  1  high while in CLEAR.

Behaviour:
- FSM states: CLEAR, SERVE.
- Reset (rst=1 at an edge):
  - state goes to CLEAR; clr_cnt=0; last_gnt=B, so A wins the first tie.
  - a_rvalid, b_rvalid, init_done, a_gnt and b_gnt are all 0; busy=1.
  - Reset asserted mid-clear restarts the sweep from address 0.
  - Reset asserted mid-read drops the pending rvalid.
- CLEAR:
  - Each cycle drives ram_we=1, ram_addr=clr_cnt, ram_din=0, then increments clr_cnt.
  - When clr_cnt==DEPTH-1 at an edge, go to SERVE.
  - The sweep takes exactly DEPTH cycles, and busy=1 throughout.
  - a_gnt and b_gnt are 0; requests are ignored, not queued.
  - clr is ignored while in CLEAR.
- SERVE arbitration (combinational):
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the requester that is not last_gnt.
  - last_gnt updates at the edge to whichever requester was granted.
  - No request: no grant, ram_we=0, and ram_addr holds its last value.
- SERVE RAM drive:
  - Granted x drives ram_we=x_we, ram_addr=x_addr, ram_din=x_wdata.
- Read latency: a granted read (x_we=0) in cycle N gives x_rvalid=1 in cycle N+1, with x_rdata=ram_dout.
  - x_rvalid is a one-cycle pulse; back-to-back reads give consecutive pulses.
  - a_rdata and b_rdata are both always wired to ram_dout; only rvalid qualifies them.
  - A write produces no rvalid.
- Clear command: clr=1 in SERVE takes priority over requests.
  - No grant is issued that cycle; the next state is CLEAR with clr_cnt=0.
  - A read granted in the previous cycle still gets its rvalid in the clr cycle. The data is intact because the RAM holds dataOut during writes.
- Same-address write then read in consecutive grants: the read returns the new data.
- A requester holds req and its signals until it sees gnt; the block keeps no request buffering.

Test Plan:
1. Reset, DEPTH=8 → busy=1 for 8 cycles, ram_we=1 with ram_addr 0..7 and ram_din=0, then init_done=1; no gnt while busy.
2. A writes 0x5A to addr 3, then A reads addr 3 → a_gnt on both cycles; a_rvalid=1 with a_rdata=0x5A one cycle after the read grant; b_rvalid stays 0.
3. A and B request continuously (A reads addr 1, B reads addr 2) → grants alternate A,B,A,B starting with A; rvalid pulses follow one cycle later with the correct per-requester data.
4. Only B requests for 3 cycles → b_gnt every cycle; a subsequent tie is then granted to A.
5. Write 0xFF to addr 7, assert clr for one cycle in SERVE → no grant that cycle; 8-cycle sweep follows; a later read of addr 7 returns 0x00.
6. Assert rst at the fourth sweep cycle → sweep restarts at addr 0 and completes 8 full cycles before init_done=1.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and sequencer that shares a single-port synchronous RAM
// between requesters A and B, and zero-fills the RAM after reset or on clr.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done,
  output logic              busy
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t              state_r, state_nxt;
  logic [CNT_W-1:0]    clr_cnt_r, clr_cnt_nxt;
  logic                last_b_r, last_b_nxt;   // 1: B was granted most recently
  logic [ADDR_W-1:0]   addr_hold_r;
  logic                a_rvalid_r, b_rvalid_r;
  logic                gnt_a_s, gnt_b_s;

  // Next-state, arbitration and RAM drive
  always_comb begin
    state_nxt   = state_r;
    clr_cnt_nxt = clr_cnt_r;
    last_b_nxt  = last_b_r;
    gnt_a_s     = 1'b0;
    gnt_b_s     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_hold_r;
    ram_din     = {DATA_W{1'b0}};
    case (state_r)
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = ADDR_W'(clr_cnt_r);
        if (clr_cnt_r == LAST_CNT) begin
          state_nxt   = SERVE;
          clr_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          clr_cnt_nxt = clr_cnt_r + CNT_W'(1);
        end
      end
      SERVE: begin
        if (clr) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = {CNT_W{1'b0}};
        end else if (a_req && (!b_req || last_b_r)) begin
          gnt_a_s    = 1'b1;
          last_b_nxt = 1'b0;
          ram_we     = a_we;
          ram_addr   = a_addr;
          ram_din    = a_wdata;
        end else if (b_req) begin
          gnt_b_s    = 1'b1;
          last_b_nxt = 1'b1;
          ram_we     = b_we;
          ram_addr   = b_addr;
          ram_din    = b_wdata;
        end else begin
          ram_we = 1'b0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, sweep counter, round-robin pointer and read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLEAR;
      clr_cnt_r   <= {CNT_W{1'b0}};
      last_b_r    <= 1'b1;
      addr_hold_r <= {ADDR_W{1'b0}};
      a_rvalid_r  <= 1'b0;
      b_rvalid_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      clr_cnt_r   <= clr_cnt_nxt;
      last_b_r    <= last_b_nxt;
      addr_hold_r <= ram_addr;
      a_rvalid_r  <= gnt_a_s & ~a_we;
      b_rvalid_r  <= gnt_b_s & ~b_we;
    end
  end

  assign a_gnt     = gnt_a_s;
  assign b_gnt     = gnt_b_s;
  assign a_rvalid  = a_rvalid_r;
  assign b_rvalid  = b_rvalid_r;
  assign a_rdata   = ram_dout;
  assign b_rdata   = ram_dout;
  assign init_done = (state_r == SERVE);
  assign busy      = (state_r == CLEAR);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a behavioural RAM, a cycle-level model of
// the arbitration/clear rules compared every cycle, plus hand-computed checks.
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic init_done, busy;

  int checks = 0;
  int failures = 0;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .init_done(init_done), .busy(busy)
  );

  // Single-port RAM: write or read each cycle; read data holds during writes.
  logic [DW-1:0] ram_mem [0:255];
  initial for (int i = 0; i < 256; i++) ram_mem[i] = 8'hA5;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  bit m_valid = 1'b0;
  bit m_clearing;
  int m_sweep;
  bit m_last_b;
  bit m_pend_a, m_pend_b;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_hold;
  logic [DW-1:0] m_mem [0:255];
  bit e_ga, e_gb, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  initial for (int i = 0; i < 256; i++) m_mem[i] = 8'hA5;

  always @(negedge clk) begin
    if (m_valid) begin
      e_ga = 1'b0; e_gb = 1'b0; e_we = 1'b0; e_addr = m_hold; e_din = 8'h00;
      if (m_clearing) begin
        e_we = 1'b1; e_addr = AW'(m_sweep);
      end else if (!clr) begin
        if (a_req && b_req) begin
          if (m_last_b) e_ga = 1'b1; else e_gb = 1'b1;
        end else if (a_req) e_ga = 1'b1;
        else if (b_req) e_gb = 1'b1;
      end
      if (e_ga) begin e_we = a_we; e_addr = a_addr; e_din = a_wdata; end
      if (e_gb) begin e_we = b_we; e_addr = b_addr; e_din = b_wdata; end
      check("a_gnt", 32'(a_gnt), 32'(e_ga));
      check("b_gnt", 32'(b_gnt), 32'(e_gb));
      check("ram_we", 32'(ram_we), 32'(e_we));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) check("ram_din", 32'(ram_din), 32'(e_din));
      check("a_rvalid", 32'(a_rvalid), 32'(m_pend_a));
      check("b_rvalid", 32'(b_rvalid), 32'(m_pend_b));
      if (m_pend_a) check("a_rdata", 32'(a_rdata), 32'(m_rdata));
      if (m_pend_b) check("b_rdata", 32'(b_rdata), 32'(m_rdata));
      check("busy", 32'(busy), 32'(m_clearing));
      check("init_done", 32'(init_done), 32'(!m_clearing));
    end
  end

  always @(posedge clk) begin
    if (m_valid) begin
      m_pend_a = e_ga && !a_we;
      m_pend_b = e_gb && !b_we;
      if (e_we) m_mem[e_addr] = e_din;
      else if (m_pend_a || m_pend_b) m_rdata = m_mem[e_addr];
      m_hold = e_addr;
      if (e_ga) m_last_b = 1'b0;
      if (e_gb) m_last_b = 1'b1;
      if (m_clearing) begin
        m_sweep++;
        if (m_sweep == DEPTH) m_clearing = 1'b0;
      end else if (clr) begin
        m_clearing = 1'b1; m_sweep = 0;
      end
    end
    if (rst) begin
      m_valid = 1'b1; m_clearing = 1'b1; m_sweep = 0; m_last_b = 1'b1;
      m_pend_a = 1'b0; m_pend_b = 1'b0; m_hold = 8'h00;
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_checks(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      #3;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_we"}, 32'(ram_we), 32'd1);
      check({tag, "_addr"}, 32'(ram_addr), 32'(i));
      check({tag, "_din"}, 32'(ram_din), 32'd0);
      check({tag, "_nogntA"}, 32'(a_gnt), 32'd0);
      go();
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    go();
    rst = 1'b0;
    // 1: initial sweep, requests ignored
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 8'h77;
    sweep_checks("t1");
    // 2: A write then read of addr 3
    a_we = 1'b1; a_addr = 8'h03; a_wdata = 8'h5A;
    #3;
    check("t2_init_done", 32'(init_done), 32'd1);
    check("t2_gnt_wr", 32'(a_gnt), 32'd1);
    go();
    a_we = 1'b0;
    #3 check("t2_gnt_rd", 32'(a_gnt), 32'd1);
    go();
    a_req = 1'b0;
    #3;
    check("t2_rvalid", 32'(a_rvalid), 32'd1);
    check("t2_rdata", 32'(a_rdata), 32'h5A);
    check("t2_b_rvalid", 32'(b_rvalid), 32'd0);
    go();
    // 3: preload addr1/addr2, then contending reads alternate A,B,A,B
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h01; a_wdata = 8'h11;
    go();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h02; b_wdata = 8'h22;
    go();
    a_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      check("t3_a_gnt", 32'(a_gnt), 32'(k % 2 == 0));
      check("t3_b_gnt", 32'(b_gnt), 32'(k % 2 == 1));
      if (k > 0) begin
        if (k % 2 == 1) check("t3_a_rdata", 32'(a_rvalid ? a_rdata : 8'hEE), 32'h11);
        else            check("t3_b_rdata", 32'(b_rvalid ? b_rdata : 8'hEE), 32'h22);
      end
      go();
    end
    a_req = 1'b0; b_req = 1'b0;
    #3 check("t3_last_b_rdata", 32'(b_rvalid ? b_rdata : 8'hEE), 32'h22);
    go();
    // 4: B alone for 3 cycles, then a tie goes to A
    b_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3 check("t4_b_gnt", 32'(b_gnt), 32'd1);
      go();
    end
    a_req = 1'b1;
    #3;
    check("t4_tie_a", 32'(a_gnt), 32'd1);
    check("t4_tie_b", 32'(b_gnt), 32'd0);
    go();
    a_req = 1'b0; b_req = 1'b0;
    go();
    // 5: write FF to 7, read 1, then clr; sweep clears addr 7
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h07; a_wdata = 8'hFF;
    go();
    a_we = 1'b0; a_addr = 8'h01;
    go();
    clr = 1'b1; a_addr = 8'h07; b_req = 1'b1;
    #3;
    check("t5_clr_a_gnt", 32'(a_gnt), 32'd0);
    check("t5_clr_b_gnt", 32'(b_gnt), 32'd0);
    check("t5_clr_we", 32'(ram_we), 32'd0);
    check("t5_clr_rvalid", 32'(a_rvalid), 32'd1);
    check("t5_clr_rdata", 32'(a_rdata), 32'h11);
    go();
    clr = 1'b0; a_req = 1'b0; b_req = 1'b0;
    sweep_checks("t5");
    a_req = 1'b1;
    #3 check("t5_rd7_gnt", 32'(a_gnt), 32'd1);
    go();
    a_req = 1'b0;
    #3;
    check("t5_rd7_rvalid", 32'(a_rvalid), 32'd1);
    check("t5_rd7_rdata", 32'(a_rdata), 32'h00);
    go();
    // 6: reset at the fourth sweep cycle restarts the sweep
    clr = 1'b1;
    go();
    clr = 1'b0;
    go(); go(); go();
    #3 check("t6_addr3", 32'(ram_addr), 32'd3);
    rst = 1'b1;
    go();
    rst = 1'b0;
    sweep_checks("t6");
    #3 check("t6_init_done", 32'(init_done), 32'd1);
    // reset during a granted read drops its rvalid
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h03; rst = 1'b1;
    go();
    rst = 1'b0; a_req = 1'b0;
    #3;
    check("t6_rvalid_dropped", 32'(a_rvalid), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    go();
    for (int i = 0; i < DEPTH; i++) go();
    #3 check("t6_final_init", 32'(init_done), 32'd1);
    go();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
